// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: scoreboard-based stall, flush and operand-forward control for an NSTAGE-latch pipeline
module pipeline_hazard_ctrl #(
  parameter int NSTAGE      = 4,
  parameter int FLUSH_DEPTH = 2,
  parameter int REG_W       = 5,
  parameter int CNT_W       = 16
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      ihit,
  input  logic                      dmem_req,
  input  logic                      dhit,
  input  logic [REG_W-1:0]          id_rsel1,
  input  logic [REG_W-1:0]          id_rsel2,
  input  logic [REG_W-1:0]          id_wsel,
  input  logic                      id_wen,
  input  logic                      id_is_load,
  input  logic                      branch_taken,
  input  logic                      wb_halt,
  output logic                      pc_en,
  output logic [NSTAGE-1:0]         pipe_en,
  output logic [NSTAGE-1:0]         flush,
  output logic [$clog2(NSTAGE)-1:0] fwd_a,
  output logic [$clog2(NSTAGE)-1:0] fwd_b,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic                      halted
);
  localparam int FW = $clog2(NSTAGE);
  typedef enum logic [1:0] {RUN, DWAIT, HALT} state_t;
  state_t r_state, w_next;
  logic [NSTAGE-1:1] r_sb_v, r_sb_wen;
  logic [REG_W-1:0] r_sb_ws [1:NSTAGE-1];
  logic r_sb_ld1;
  logic r_halted;
  logic [CNT_W-1:0] r_cnt;
  logic w_dwait, w_lu;
  assign w_dwait = dmem_req & ~dhit;
  assign w_lu = r_sb_v[1] & r_sb_ld1 & r_sb_wen[1] & (r_sb_ws[1] != '0) &
                ((r_sb_ws[1] == id_rsel1) | (r_sb_ws[1] == id_rsel2));
  assign stall_cnt = r_cnt;
  assign halted = r_halted;
  // prioritised enable/flush response and next state (halt entered once it reaches the last latch while advancing)
  always_comb begin
    pc_en = 1'b1;
    pipe_en = '1;
    flush = '0;
    if (!nRST) begin
      pc_en = 1'b0;
      pipe_en = '0;
      flush = '1;
    end else if (r_state == HALT || w_dwait || !ihit) begin
      pc_en = 1'b0;
      pipe_en = '0;
    end else if (branch_taken) begin
      flush = {{(NSTAGE-FLUSH_DEPTH){1'b0}}, {FLUSH_DEPTH{1'b1}}};
    end else if (w_lu) begin
      pc_en = 1'b0;
      pipe_en[0] = 1'b0;
      flush[1] = 1'b1;
    end
    w_next = r_state;
    if (r_state != HALT)
      w_next = (wb_halt & pipe_en[NSTAGE-1]) ? HALT : w_dwait ? DWAIT : RUN;
  end
  // youngest matching producer wins; a load still in latch 1 is covered by the load-use stall instead
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (nRST)
      for (int k = NSTAGE-1; k >= 1; k--)
        if (r_sb_v[k] && r_sb_wen[k] && r_sb_ws[k] != '0 && !(k == 1 && r_sb_ld1)) begin
          if (r_sb_ws[k] == id_rsel1) fwd_a = FW'(k);
          if (r_sb_ws[k] == id_rsel2) fwd_b = FW'(k);
        end
  end
  // state register, sticky halt flag and saturating stall counter
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_halted <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == HALT) r_halted <= 1'b1;
      if (!pc_en && r_state != HALT && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  // scoreboard shifts with the latches it shadows; a flushed latch receives an empty entry
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sb_v <= '0;
      r_sb_wen <= '0;
      r_sb_ld1 <= 1'b0;
      for (int k = 1; k < NSTAGE; k++) r_sb_ws[k] <= '0;
    end else begin
      if (pipe_en[1]) begin
        r_sb_v[1] <= ~flush[1];
        r_sb_wen[1] <= id_wen;
        r_sb_ld1 <= id_is_load;
        r_sb_ws[1] <= id_wsel;
      end
      for (int k = 2; k < NSTAGE; k++)
        if (pipe_en[k]) begin
          r_sb_v[k] <= r_sb_v[k-1] & ~flush[k];
          r_sb_wen[k] <= r_sb_wen[k-1];
          r_sb_ws[k] <= r_sb_ws[k-1];
        end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and randomized checks against an instruction-level pipeline model
module tb_pipeline_hazard_ctrl;
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  logic ihit, dmem_req, dhit, id_wen, id_is_load, branch_taken, wb_halt;
  logic [4:0] id_rsel1, id_rsel2, id_wsel;
  logic pc_en, halted;
  logic [3:0] pipe_en, flush;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  logic b_ihit, b_dmem_req, b_dhit, b_id_wen, b_id_is_load, b_branch_taken, b_wb_halt;
  logic [4:0] b_id_rsel1, b_id_rsel2, b_id_wsel;
  logic b_pc_en, b_halted;
  logic [5:0] b_pipe_en, b_flush;
  logic [2:0] b_fwd_a, b_fwd_b;
  logic [3:0] b_stall_cnt;

  pipeline_hazard_ctrl #(.NSTAGE(4), .FLUSH_DEPTH(2), .REG_W(5), .CNT_W(16)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmem_req(dmem_req), .dhit(dhit),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2), .id_wsel(id_wsel), .id_wen(id_wen),
    .id_is_load(id_is_load), .branch_taken(branch_taken), .wb_halt(wb_halt),
    .pc_en(pc_en), .pipe_en(pipe_en), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .halted(halted));

  pipeline_hazard_ctrl #(.NSTAGE(6), .FLUSH_DEPTH(3), .REG_W(5), .CNT_W(4)) u_dut_b (
    .CLK(CLK), .nRST(nRST), .ihit(b_ihit), .dmem_req(b_dmem_req), .dhit(b_dhit),
    .id_rsel1(b_id_rsel1), .id_rsel2(b_id_rsel2), .id_wsel(b_id_wsel), .id_wen(b_id_wen),
    .id_is_load(b_id_is_load), .branch_taken(b_branch_taken), .wb_halt(b_wb_halt),
    .pc_en(b_pc_en), .pipe_en(b_pipe_en), .flush(b_flush), .fwd_a(b_fwd_a), .fwd_b(b_fwd_b),
    .stall_cnt(b_stall_cnt), .halted(b_halted));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // instruction-level model of the 4-latch pipe: what occupies latches 1..3
  typedef struct {bit v; bit w; bit ld; int rd;} ins_t;
  ins_t m_p[1:3];
  bit m_halt;
  int m_cnt;
  bit e_pc;
  logic [3:0] e_pe, e_fl;
  int e_fa, e_fb;

  function automatic int fwd_of(input int rs);
    for (int k = 1; k <= 3; k++)
      if (rs != 0 && m_p[k].v && m_p[k].w && m_p[k].rd == rs && !(k == 1 && m_p[k].ld)) return k;
    return 0;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= 3; k++) m_p[k] = '{0, 0, 0, 0};
    m_halt = 0;
    m_cnt = 0;
  endtask

  task automatic model_eval();
    bit lu;
    lu = m_p[1].v && m_p[1].ld && m_p[1].w && m_p[1].rd != 0 &&
         (m_p[1].rd == int'(id_rsel1) || m_p[1].rd == int'(id_rsel2));
    e_fa = fwd_of(int'(id_rsel1));
    e_fb = fwd_of(int'(id_rsel2));
    if (m_halt || (dmem_req && !dhit) || !ihit) begin e_pc = 0; e_pe = 4'h0; e_fl = 4'h0; end
    else if (branch_taken) begin e_pc = 1; e_pe = 4'hf; e_fl = 4'b0011; end
    else if (lu) begin e_pc = 0; e_pe = 4'b1110; e_fl = 4'b0010; end
    else begin e_pc = 1; e_pe = 4'hf; e_fl = 4'h0; end
  endtask

  task automatic model_adv();
    bit nh;
    nh = m_halt || (wb_halt && e_pe[3]);
    if (!e_pc && !m_halt && m_cnt < 65535) m_cnt++;
    for (int k = 3; k >= 2; k--)
      if (e_pe[k]) m_p[k] = e_fl[k] ? '{0, 0, 0, 0} : m_p[k-1];
    if (e_pe[1]) m_p[1] = e_fl[1] ? '{0, 0, 0, 0} : '{1'b1, id_wen, id_is_load, int'(id_wsel)};
    m_halt = nh;
  endtask

  task automatic step();
    model_eval();
    @(negedge CLK);
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("pipe_en", 32'(pipe_en), 32'(e_pe));
    chk("flush", 32'(flush), 32'(e_fl));
    chk("fwd_a", 32'(fwd_a), e_fa);
    chk("fwd_b", 32'(fwd_b), e_fb);
    chk("stall_cnt", 32'(stall_cnt), m_cnt);
    chk("halted", 32'(halted), 32'(m_halt));
    @(posedge CLK);
    model_adv();
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_pipe_en", 32'(pipe_en), 0);
    chk("rst_flush", 32'(flush), 32'hf);
    chk("rst_fwd_a", 32'(fwd_a), 0);
    chk("rst_fwd_b", 32'(fwd_b), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    @(posedge CLK);
    #2 nRST = 1'b1;
    model_clear();
  endtask

  task automatic idle();
    ihit = 1; dmem_req = 0; dhit = 0; branch_taken = 0; wb_halt = 0;
    id_wen = 0; id_is_load = 0; id_wsel = 0; id_rsel1 = 0; id_rsel2 = 0;
  endtask

  task automatic set_ins(input int ws, input int r1, input int r2, input int wen, input int ld);
    id_wsel = 5'(ws); id_rsel1 = 5'(r1); id_rsel2 = 5'(r2);
    id_wen = 1'(wen); id_is_load = 1'(ld);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    b_ihit = 1; b_dmem_req = 0; b_dhit = 0; b_branch_taken = 0; b_wb_halt = 0;
    b_id_wen = 0; b_id_is_load = 0; b_id_wsel = 0; b_id_rsel1 = 0; b_id_rsel2 = 0;
    model_clear();
    #1 do_reset();
    set_ins(5, 0, 0, 1, 1);
    step();
    set_ins(6, 5, 1, 1, 0);
    #1;
    chk("lu_pc_en", 32'(pc_en), 0);
    chk("lu_pipe_en", 32'(pipe_en), 32'b1110);
    chk("lu_flush", 32'(flush), 32'b0010);
    step();
    #1;
    chk("lu_next_fwd_a", 32'(fwd_a), 2);
    chk("lu_next_cnt", 32'(stall_cnt), 1);
    step();
    do_reset();
    idle();
    set_ins(3, 0, 0, 1, 0);
    step();
    set_ins(4, 3, 3, 1, 0);
    #1;
    chk("b2b_fwd_a", 32'(fwd_a), 1);
    chk("b2b_fwd_b", 32'(fwd_b), 1);
    chk("b2b_pc_en", 32'(pc_en), 1);
    step();
    set_ins(7, 3, 0, 1, 0);
    #1 chk("dist2_fwd_a", 32'(fwd_a), 2);
    step();
    set_ins(0, 0, 0, 1, 0);
    step();
    set_ins(8, 0, 0, 1, 0);
    #1;
    chk("r0_fwd_a", 32'(fwd_a), 0);
    chk("r0_fwd_b", 32'(fwd_b), 0);
    step();
    do_reset();
    idle();
    dmem_req = 1;
    repeat (3) begin
      #1;
      chk("dwait_pipe_en", 32'(pipe_en), 0);
      chk("dwait_pc_en", 32'(pc_en), 0);
      step();
    end
    dhit = 1;
    #1;
    chk("dwait_resume_pipe_en", 32'(pipe_en), 32'hf);
    chk("dwait_cnt", 32'(stall_cnt), 3);
    step();
    do_reset();
    idle();
    set_ins(5, 0, 0, 1, 1);
    step();
    set_ins(6, 5, 0, 1, 0);
    branch_taken = 1;
    #1;
    chk("br_lu_pc_en", 32'(pc_en), 1);
    chk("br_lu_pipe_en", 32'(pipe_en), 32'hf);
    chk("br_lu_flush", 32'(flush), 32'b0011);
    step();
    do_reset();
    idle();
    wb_halt = 1;
    step();
    wb_halt = 0;
    repeat (4) begin
      #1;
      chk("halt_pipe_en", 32'(pipe_en), 0);
      chk("halt_halted", 32'(halted), 1);
      step();
    end
    do_reset();
    repeat (3) step();
    for (int i = 0; i < 3000; i++) begin
      ihit = $urandom_range(0, 99) < 85;
      dmem_req = $urandom_range(0, 99) < 25;
      dhit = $urandom_range(0, 1) == 1;
      branch_taken = $urandom_range(0, 99) < 12;
      wb_halt = $urandom_range(0, 199) == 0;
      set_ins(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 99) < 70), int'($urandom_range(0, 99) < 35));
      step();
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
    end
    idle();
    do_reset();
    b_id_wsel = 5; b_id_wen = 1; b_id_is_load = 1;
    @(posedge CLK);
    #1;
    b_id_wsel = 6; b_id_rsel1 = 5; b_id_is_load = 0;
    #1;
    chk("b_lu_pipe_en", 32'(b_pipe_en), 32'b111110);
    chk("b_lu_flush", 32'(b_flush), 32'b000010);
    b_branch_taken = 1;
    #1;
    chk("b_br_pc_en", 32'(b_pc_en), 1);
    chk("b_br_pipe_en", 32'(b_pipe_en), 32'h3f);
    chk("b_br_flush", 32'(b_flush), 32'b000111);
    @(posedge CLK);
    #1;
    b_branch_taken = 0; b_id_wen = 0; b_id_rsel1 = 0; b_ihit = 0;
    #1 chk("b_cnt_start", 32'(b_stall_cnt), 0);
    repeat (5) @(posedge CLK);
    #1 chk("b_cnt_5", 32'(b_stall_cnt), 5);
    repeat (15) @(posedge CLK);
    #1 chk("b_cnt_sat", 32'(b_stall_cnt), 15);
    repeat (5) @(posedge CLK);
    #1;
    chk("b_cnt_hold", 32'(b_stall_cnt), 15);
    chk("b_halted", 32'(b_halted), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard, stall and forwarding controller for the pipelined datapath. It is the successor to the fixed four-latch hazard unit. It keeps a registered scoreboard of in-flight destination registers and runs a stall FSM covering instruction miss, data-memory wait, load-use and halt. It drives per-latch enable/flush vectors and operand-forward selects. It sits beside the datapath between the cache handshake signals and the pipeline latches.

## Interface
- NSTAGE, 4, number of pipeline latches (latch 0 = IF/ID … NSTAGE-1 = MEM/WB); legal ≥3
- FLUSH_DEPTH, 2, latches 0..FLUSH_DEPTH-1 bubbled on a taken branch; legal 1..NSTAGE-1
- REG_W, 5, register-select width
- CNT_W, 16, stall-counter width
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous reset, active low
- ihit  in  1  instruction fetch complete this cycle
- dmem_req  in  1  instruction in MEM issues dren/dwen
- dhit  in  1  data access complete this cycle
- id_rsel1, id_rsel2  in  REG_W  sources of instruction in ID
- id_wsel  in  REG_W  destination of instruction in ID
- id_wen, id_is_load  in  1  ID instruction writes a register / is a load
- branch_taken  in  1  EX resolved a redirect (branch/jump)
- wb_halt  in  1  halt instruction in latch NSTAGE-1
- pc_en  out  1  PC update enable
- pipe_en  out  NSTAGE  per-latch load enable
- flush  out  NSTAGE  per-latch bubble insert (load zero/NOP when pipe_en)
- fwd_a, fwd_b  out  $clog2(NSTAGE)  forward source for rsel1/rsel2; 0 = register file, k = latch k
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- halted  out  1  sticky halt indicator

## Operation
- Scoreboard: entries sb[1..NSTAGE-1] of {valid, wen, is_load, wsel}. On pipe_en[k]: sb[k] ← sb[k-1] (sb[1] ← ID fields), or invalid if flush[k]. When pipe_en[k]=0, sb[k] holds.
- States: RUN, DWAIT, HALT. Load-use and ihit stalls are combinational conditions within RUN.
- Condition priority, highest first:
  - HALT: all pipe_en=0, pc_en=0, flush=0; exit only by reset.
  - dwait = dmem_req & !dhit: enter/remain DWAIT; all pipe_en=0, pc_en=0.
  - !ihit: pc_en=0, pipe_en=0 for all latches.
  - taken branch: pc_en=1, all pipe_en=1, flush[0..FLUSH_DEPTH-1]=1. A branch overrides a simultaneous load-use.
  - load-use: sb[1] valid & is_load & wen & wsel≠0 & wsel ∈ {id_rsel1, id_rsel2}. Response: pc_en=0, pipe_en[0]=0, pipe_en[1..]=1, flush[1]=1.
  - else: all enables 1, flush 0.
- DWAIT→RUN on dhit.
- Any state→HALT on wb_halt & pipe_en would be 1 (halt reaches end of pipe); halted=1 thereafter.
- Forwarding: fwd_a = smallest k ≥1 with sb[k].valid & wen & wsel==id_rsel1 & wsel≠0, else 0. Load entries in latch 1 never forward (a stall covers them). fwd_b likewise for id_rsel2. A register-0 source always gives 0.
- stall_cnt increments when pc_en=0 and state≠HALT; saturates at all-ones.

## Timing
- Scoreboard, state, stall_cnt and halted are registered. All other outputs are combinational from the registered state and current inputs, so they settle within the same cycle.
- Load-use costs exactly 1 cycle; the bubble occupies sb[1] the next cycle.
- Taken-branch penalty: FLUSH_DEPTH bubbles, no extra stall cycle.
- DWAIT adds one cycle per cycle dhit stays low; the pipe resumes on the dhit cycle.
- While nRST low (asynchronous): scoreboard invalid, state RUN, stall_cnt 0, halted 0. Outputs are forced to pc_en=0, pipe_en=0, flush=all ones, fwd 0.
- Reset mid-DWAIT or mid-HALT: returns to RUN with an empty scoreboard on the first edge after release.

## Test plan
- NSTAGE=4, lw r5 then add r6,r5,r1 (ihit=1, dmem_req=0) → one cycle pc_en=0, pipe_en=4'b1110, flush=4'b0010. Next cycle fwd_a=2, stall_cnt=1.
- add r3 then sub r4,r3,r3 back-to-back → no stall, fwd_a=fwd_b=1. Second dependent two instructions later → fwd=2. Source r0 with producer r0 → fwd=0.
- dmem_req=1, dhit low 3 cycles → pipe_en=0 and pc_en=0 for 3 cycles in DWAIT, RUN on the dhit cycle, stall_cnt=3.
- branch_taken coincident with load-use, FLUSH_DEPTH=2 → pc_en=1, pipe_en=all ones, flush=4'b0011. Repeat at NSTAGE=6, FLUSH_DEPTH=3 → flush=6'b000111.
- wb_halt with pipe advancing → halted=1, all enables 0 indefinitely. Assert nRST low mid-halt → outputs forced immediately, halted=0, RUN after release.
- CNT_W=4, hold ihit=0 for 20 cycles → stall_cnt saturates at 15.
